// File: rtl/hex_ascii_parser_if.sv
// Character-in / word-out handshake bundle for the ASCII hex parser.
// The parser takes the slave side; the character source and word consumer take master.
interface hex_ascii_parser_if #(
  parameter int WIDTH = 32
);
  localparam int MAXD = WIDTH / 4;
  localparam int CW   = $clog2(MAXD + 1);

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_value;
  logic [CW-1:0]    out_digits;
  logic             out_ready;
  logic             err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_value, out_digits, err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_value, out_digits, err
  );
endinterface

// File: rtl/hex_ascii_parser.sv
// Streaming ASCII hex text to binary word parser: one word per delimited token,
// optional 0x/0X prefix, one-cycle err pulse on the first malformed character of a token.
module hex_ascii_parser #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  hex_ascii_parser_if.slave bus
);
  localparam int MAXD = WIDTH / 4;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGITS,
    S_SKIP,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_pfx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_value;
  logic [CW-1:0]    r_out_digits;
  logic             r_err;

  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_delim;
  logic             w_is_x;
  logic [3:0]       w_nibble;
  logic [WIDTH-1:0] w_acc_shift;

  assign w_accept = bus.in_valid && r_in_ready;

  always_comb begin
    w_is_digit = 1'b0;
    w_is_delim = 1'b0;
    w_is_x     = 1'b0;
    w_nibble   = 4'h0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      w_is_digit = 1'b1;
      w_nibble   = bus.in_data[3:0];
    end else if ((bus.in_data >= 8'h41 && bus.in_data <= 8'h46) ||
                 (bus.in_data >= 8'h61 && bus.in_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      w_is_digit = 1'b1;
      w_nibble   = bus.in_data[3:0] + 4'd9;
    end else if (bus.in_data == 8'h78 || bus.in_data == 8'h58) begin
      w_is_x = 1'b1;
    end else if (bus.in_data == 8'h20 || bus.in_data == 8'h09 || bus.in_data == 8'h0D ||
                 bus.in_data == 8'h0A || bus.in_data == 8'h2C) begin
      w_is_delim = 1'b1;
    end
  end

  generate
    if (WIDTH == 4) begin : g_narrow
      assign w_acc_shift = w_nibble;
    end else begin : g_wide
      assign w_acc_shift = {r_acc[WIDTH-5:0], w_nibble};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_pfx        <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_value  <= '0;
      r_out_digits <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_digit) begin
              r_acc   <= WIDTH'(w_nibble);
              r_cnt   <= CW'(1);
              r_pfx   <= 1'b0;
              r_state <= S_DIGITS;
            end else if (!w_is_delim) begin
              r_err   <= 1'b1;
              r_state <= S_SKIP;
            end
          end
        end
        S_DIGITS: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (r_cnt == CW'(MAXD)) begin
                r_err   <= 1'b1;
                r_state <= S_SKIP;
              end else begin
                r_acc <= w_acc_shift;
                r_cnt <= r_cnt + CW'(1);
              end
            end else if (w_is_x) begin
              // Only a lone leading '0' may turn into a prefix
              if (r_cnt == CW'(1) && r_acc == '0 && !r_pfx) begin
                r_pfx <= 1'b1;
                r_cnt <= '0;
                r_acc <= '0;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_SKIP;
              end
            end else if (w_is_delim) begin
              if (r_cnt != '0) begin
                r_out_value  <= r_acc;
                r_out_digits <= r_cnt;
                r_out_valid  <= 1'b1;
                r_in_ready   <= 1'b0;
                r_state      <= S_OUT;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          if (w_accept && w_is_delim) begin
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_value  = r_out_value;
  assign bus.out_digits = r_out_digits;
  assign bus.err        = r_err;
endmodule
